ref_pulse_meas: RTL and testbench
=================================

Name: ref_pulse_meas

Overview:
- Measures the pulse train produced by the reference-signal generator (ref_signal) in the same 500 MHz domain; sits directly downstream of it.
- After an arm strobe, it captures the offset to the first rising edge, the last and min/max period, the last high width, and the pulse count.
- Flags completion after the expected number of pulses, or a timeout if the signal goes silent.
- Used for self-check of generator settings (sig_start, sig_period, duty_cycle, cnt_nums).

Parameters:
CNT_W, 32, width of all time counters and measurement outputs
NUM_W, 8, width of pulse count and expected-count input

Ports:
ref_clk_500m  in   1      sole clock, rising edge
reset         in   1      asynchronous, active-high; clears all state and outputs
arm           in   1      start/restart measurement on its rising edge
sig_in        in   1      pulse train under test; same clock domain, glitch-free
exp_nums      in   NUM_W  number of pulses to measure; sampled at arm
timeout       in   CNT_W  max cycles without an sig_in edge; 0 disables; sampled at arm
meas_offset   out  CNT_W  cycles from arm detect to first rise detect
meas_period   out  CNT_W  last rise-to-rise interval, in cycles
period_min    out  CNT_W  minimum rise-to-rise interval
period_max    out  CNT_W  maximum rise-to-rise interval
meas_high     out  CNT_W  last rise-to-fall interval, in cycles
pulse_cnt     out  NUM_W  rising edges counted since arm
busy          out  1      high in WAIT_FIRST and MEASURE
done          out  1      high in DONE; held until next arm or reset
timeout_err   out  1      set with done when the timeout ended the run

Behaviour:
- Reset values: all outputs 0, except period_min = all-ones. State = IDLE. arm_d = 0, sig_d = 0.
- Edge detection, one cycle, registered:
  - arm_rise = arm & ~arm_d
  - rise = sig_in & ~sig_d
  - fall = ~sig_in & sig_d
- States: IDLE, WAIT_FIRST, MEASURE, DONE.
- arm_rise in any state (including mid-run abort):
  - Latch exp_nums and timeout.
  - Clear all measurement outputs, done and timeout_err; period_min goes to all-ones.
  - Clear the timer and silence counter.
  - Next state is WAIT_FIRST; if the latched exp_nums == 0, go straight to DONE instead, with pulse_cnt = 0.
- WAIT_FIRST:
  - Timer increments every edge; the arm_rise edge loads 0.
  - On rise: meas_offset <= timer + 1 (the arm seen at edge 0 and the rise seen at edge N give N), pulse_cnt <= 1, period timer and high timer <= 1, state -> MEASURE.
- MEASURE:
  - Period timer and high timer increment each edge.
  - On fall: meas_high <= high timer. If pulse_cnt == latched exp_nums, state -> DONE on the same edge.
  - On rise: meas_period <= period timer; update period_min/period_max; pulse_cnt +1; period timer and high timer <= 1.
- Timeout:
  - The silence counter clears on rise, fall or arm_rise, and increments otherwise while busy.
  - If timeout != 0 and the counter reaches timeout - 1 with no edge this cycle: timeout_err <= 1, state -> DONE.
  - Partial results are kept.
- DONE: done = 1, busy = 0; outputs frozen until arm_rise or reset.
- Arithmetic:
  - All timers saturate at all-ones and never wrap.
  - pulse_cnt saturates at all-ones.
  - Every comparison uses the latched values; live input changes after arm are ignored.
- Simultaneous events:
  - arm_rise has priority over everything.
  - A timeout on the same edge as rise/fall is suppressed (the edge wins).
- sig_in already high at arm: no rise is seen until sig_in falls and rises again.
- IDLE: busy = 0, done = 0; waits for arm_rise.

Test Plan:
1. reset high, then arm at edge 0 (exp_nums=3, timeout=0); sig_in rises at edges 10, 30, 50 and falls at 15, 35, 55 -> meas_offset=10, meas_period=20, period_min=period_max=20, meas_high=5, pulse_cnt=3; done rises after edge 55; busy low.
2. Jitter: exp_nums=4; rises at 5, 25, 47, 66 -> period_min=19, period_max=22, meas_period=19.
3. Timeout: exp_nums=5, timeout=100; one pulse (rise 10, fall 12), then silence -> timeout_err=1, done=1 at edge 111 (counter reaches 99); pulse_cnt=1, meas_high=2.
4. exp_nums=0 -> done=1 one edge after arm_rise, pulse_cnt=0, timeout_err=0.
5. Re-arm mid-MEASURE after 2 pulses -> all outputs cleared, period_min=all-ones; the next measurement is correct relative to the new arm.
6. Assert reset asynchronously mid-MEASURE -> all outputs zero immediately (period_min all-ones), state IDLE; sig_in edges ignored until arm.

Source files
------------

// File: rtl/ref_pulse_meas.sv
// Measures the pulse train from ref_signal after an arm strobe: offset to the first rise,
// last/min/max period, last high width and pulse count. Flags done or a silence timeout.
//
// state      | meaning
// IDLE       | after reset, waiting for an arm rising edge
// WAIT_FIRST | armed, timing until the first rising edge of sig_in
// MEASURE    | counting pulses, measuring period and high width
// DONE       | results frozen until the next arm or reset

module ref_pulse_meas #(
    parameter int CNT_W = 32,
    parameter int NUM_W = 8
) (
    input  logic             ref_clk_500m,
    input  logic             reset,
    input  logic             arm,
    input  logic             sig_in,
    input  logic [NUM_W-1:0] exp_nums,
    input  logic [CNT_W-1:0] timeout,
    output logic [CNT_W-1:0] meas_offset,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max,
    output logic [CNT_W-1:0] meas_high,
    output logic [NUM_W-1:0] pulse_cnt,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_MEASURE    = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);
    localparam logic [NUM_W-1:0] NUM_MAX = {NUM_W{1'b1}};

    state_t           state_q;
    logic             arm_dly_q;
    logic             sig_dly_q;
    logic [NUM_W-1:0] exp_q;
    logic [CNT_W-1:0] tmo_q;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] per_tmr_q;
    logic [CNT_W-1:0] high_tmr_q;
    logic [CNT_W-1:0] sil_q;
    logic [CNT_W-1:0] offset_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] pmin_q;
    logic [CNT_W-1:0] pmax_q;
    logic [CNT_W-1:0] high_q;
    logic [NUM_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             terr_q;

    logic             arm_rise;
    logic             rise;
    logic             fall;
    logic             sig_edge;
    logic [CNT_W-1:0] timer_d;
    logic [CNT_W-1:0] per_tmr_d;
    logic [CNT_W-1:0] high_tmr_d;
    logic [CNT_W-1:0] sil_d;
    logic [NUM_W-1:0] cnt_d;
    logic             tmo_fire;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [NUM_W-1:0] sat_num(input logic [NUM_W-1:0] v);
        return (v == NUM_MAX) ? v : v + NUM_ONE;
    endfunction

    assign arm_rise = arm & ~arm_dly_q;
    assign rise     = sig_in & ~sig_dly_q;
    assign fall     = ~sig_in & sig_dly_q;
    assign sig_edge = rise | fall;

    assign timer_d    = sat_cnt(timer_q);
    assign per_tmr_d  = sat_cnt(per_tmr_q);
    assign high_tmr_d = sat_cnt(high_tmr_q);
    assign sil_d      = sat_cnt(sil_q);
    assign cnt_d      = sat_num(cnt_q);

    // Fires on the edge where the silence count reaches timeout-1; any sig_in edge wins.
    assign tmo_fire = busy_q & ~sig_edge & (tmo_q != '0) & (sil_d >= tmo_q - CNT_ONE);

    always_ff @(posedge ref_clk_500m or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            arm_dly_q  <= 1'b0;
            sig_dly_q  <= 1'b0;
            exp_q      <= '0;
            tmo_q      <= '0;
            timer_q    <= '0;
            per_tmr_q  <= '0;
            high_tmr_q <= '0;
            sil_q      <= '0;
            offset_q   <= '0;
            period_q   <= '0;
            pmin_q     <= CNT_MAX;
            pmax_q     <= '0;
            high_q     <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            arm_dly_q <= arm;
            sig_dly_q <= sig_in;

            if (arm_rise) begin
                exp_q      <= exp_nums;
                tmo_q      <= timeout;
                timer_q    <= '0;
                per_tmr_q  <= '0;
                high_tmr_q <= '0;
                sil_q      <= '0;
                offset_q   <= '0;
                period_q   <= '0;
                pmin_q     <= CNT_MAX;
                pmax_q     <= '0;
                high_q     <= '0;
                cnt_q      <= '0;
                terr_q     <= 1'b0;
                if (exp_nums == '0) begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= ST_WAIT_FIRST;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_WAIT_FIRST: begin
                        timer_q <= timer_d;
                        sil_q   <= sig_edge ? '0 : sil_d;
                        if (rise) begin
                            offset_q   <= timer_d;
                            cnt_q      <= NUM_ONE;
                            per_tmr_q  <= CNT_ONE;
                            high_tmr_q <= CNT_ONE;
                            state_q    <= ST_MEASURE;
                        end else if (tmo_fire) begin
                            terr_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end

                    ST_MEASURE: begin
                        per_tmr_q  <= per_tmr_d;
                        high_tmr_q <= high_tmr_d;
                        sil_q      <= sig_edge ? '0 : sil_d;
                        if (fall) begin
                            high_q <= high_tmr_q;
                            if (cnt_q == exp_q) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                        end else if (rise) begin
                            period_q <= per_tmr_q;
                            if (per_tmr_q < pmin_q) begin
                                pmin_q <= per_tmr_q;
                            end
                            if (per_tmr_q > pmax_q) begin
                                pmax_q <= per_tmr_q;
                            end
                            cnt_q      <= cnt_d;
                            per_tmr_q  <= CNT_ONE;
                            high_tmr_q <= CNT_ONE;
                        end else if (tmo_fire) begin
                            terr_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end

                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end

                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign meas_offset = offset_q;
    assign meas_period = period_q;
    assign period_min  = pmin_q;
    assign period_max  = pmax_q;
    assign meas_high   = high_q;
    assign pulse_cnt   = cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_ref_pulse_meas.sv
// Directed bench for ref_pulse_meas: table of armed runs with hand-computed results,
// plus re-arm and asynchronous-reset sequences.

module tb_ref_pulse_meas;

    localparam int CNT_W = 32;
    localparam int NUM_W = 8;
    localparam int NONE  = 1000;
    localparam int NVEC  = 10;
    localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

    logic             ref_clk_500m;
    logic             reset;
    logic             arm;
    logic             sig_in;
    logic [NUM_W-1:0] exp_nums;
    logic [CNT_W-1:0] timeout;
    logic [CNT_W-1:0] meas_offset;
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] period_min;
    logic [CNT_W-1:0] period_max;
    logic [CNT_W-1:0] meas_high;
    logic [NUM_W-1:0] pulse_cnt;
    logic             busy;
    logic             done;
    logic             timeout_err;

    int n_vec = 0;
    int n_err = 0;

    ref_pulse_meas #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .ref_clk_500m (ref_clk_500m),
        .reset        (reset),
        .arm          (arm),
        .sig_in       (sig_in),
        .exp_nums     (exp_nums),
        .timeout      (timeout),
        .meas_offset  (meas_offset),
        .meas_period  (meas_period),
        .period_min   (period_min),
        .period_max   (period_max),
        .meas_high    (meas_high),
        .pulse_cnt    (pulse_cnt),
        .busy         (busy),
        .done         (done),
        .timeout_err  (timeout_err)
    );

    initial ref_clk_500m = 1'b0;
    always #5 ref_clk_500m = ~ref_clk_500m;

    // Edge numbers are relative to the arm edge (edge 0); sig_in is high on edges in [r, f).
    typedef struct {
        int          exp_n;
        int          tmo;
        int          r0, f0, r1, f1, r2, f2, r3, f3;
        int          run;
        logic [31:0] e_off, e_per, e_min, e_max, e_high;
        int          e_cnt;
        logic        e_busy, e_done, e_terr;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic logic lvl(input vec_t v, input int n);
        return (n >= v.r0 && n < v.f0) || (n >= v.r1 && n < v.f1) ||
               (n >= v.r2 && n < v.f2) || (n >= v.r3 && n < v.f3);
    endfunction

    task automatic chk(input string name, input int vid, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s (case %0d): got %0d, expected %0d", name, vid, act, exp_v);
        end
    endtask

    task automatic chk_outs(input int vid, input logic [31:0] off, input logic [31:0] per,
                            input logic [31:0] pmin, input logic [31:0] pmax,
                            input logic [31:0] high, input int cnt,
                            input logic bsy, input logic dn, input logic terr);
        chk("meas_offset", vid, meas_offset, off);
        chk("meas_period", vid, meas_period, per);
        chk("period_min",  vid, period_min,  pmin);
        chk("period_max",  vid, period_max,  pmax);
        chk("meas_high",   vid, meas_high,   high);
        chk("pulse_cnt",   vid, 32'(pulse_cnt), 32'(cnt));
        chk("busy",        vid, 32'(busy),        32'(bsy));
        chk("done",        vid, 32'(done),        32'(dn));
        chk("timeout_err", vid, 32'(timeout_err), 32'(terr));
    endtask

    task automatic cyc(input logic a, input logic s);
        arm    = a;
        sig_in = s;
        @(posedge ref_clk_500m);
        @(negedge ref_clk_500m);
    endtask

    task automatic run_vec(input int vid);
        vec_t v;
        v = vecs[vid];
        cyc(1'b0, lvl(v, -2));
        cyc(1'b0, lvl(v, -1));
        for (int n = 0; n <= v.run; n++) begin
            if (n == 0) begin
                exp_nums = NUM_W'(v.exp_n);
                timeout  = CNT_W'(v.tmo);
            end else begin
                exp_nums = 8'd200;
                timeout  = 32'd3;
            end
            cyc(n == 0, lvl(v, n));
        end
        chk_outs(vid, v.e_off, v.e_per, v.e_min, v.e_max, v.e_high, v.e_cnt,
                 v.e_busy, v.e_done, v.e_terr);
    endtask

    initial begin
        //           exp tmo  r0  f0    r1    f1    r2    f2    r3    f3   run  off per  min   max high cnt b d t
        vecs[0] = '{3, 0,   10, 15,   30,   35,   50,   55,   NONE, NONE, 60,  10, 20, 20,   20, 5,  3,  0,1,0};
        vecs[1] = '{3, 0,   10, 15,   30,   35,   50,   55,   NONE, NONE, 54,  10, 20, 20,   20, 5,  3,  1,0,0};
        vecs[2] = '{4, 0,   5,  8,    25,   28,   47,   50,   66,   70,   75,  5,  19, 19,   22, 4,  4,  0,1,0};
        vecs[3] = '{5, 100, 10, 12,   NONE, NONE, NONE, NONE, NONE, NONE, 110, 10, 0,  ALL1, 0,  2,  1,  1,0,0};
        vecs[4] = '{5, 100, 10, 12,   NONE, NONE, NONE, NONE, NONE, NONE, 111, 10, 0,  ALL1, 0,  2,  1,  0,1,1};
        vecs[5] = '{0, 0,   NONE,NONE,NONE, NONE, NONE, NONE, NONE, NONE, 0,   0,  0,  ALL1, 0,  0,  0,  0,1,0};
        vecs[6] = '{1, 0,   -2, 6,    20,   24,   NONE, NONE, NONE, NONE, 30,  20, 0,  ALL1, 0,  4,  1,  0,1,0};
        vecs[7] = '{2, 8,   NONE,NONE,NONE, NONE, NONE, NONE, NONE, NONE, 7,   0,  0,  ALL1, 0,  0,  0,  0,1,1};
        vecs[8] = '{2, 8,   NONE,NONE,NONE, NONE, NONE, NONE, NONE, NONE, 6,   0,  0,  ALL1, 0,  0,  0,  1,0,0};
        vecs[9] = '{3, 10,  9,  12,   15,   18,   21,   24,   NONE, NONE, 30,  9,  6,  6,    6,  3,  3,  0,1,0};

        reset    = 1'b1;
        arm      = 1'b0;
        sig_in   = 1'b0;
        exp_nums = '0;
        timeout  = '0;
        repeat (3) @(negedge ref_clk_500m);
        chk_outs(99, 0, 0, ALL1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Re-arm mid-MEASURE after two pulses, with a new expected count.
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        exp_nums = 8'd4;
        timeout  = 32'd0;
        cyc(1'b1, 1'b0);
        exp_nums = 8'd200;
        timeout  = 32'd3;
        for (int n = 1; n <= 24; n++) begin
            cyc(1'b0, (n >= 10 && n < 13) || (n >= 20 && n < 23));
        end
        chk("rearm_pre_cnt", 100, 32'(pulse_cnt), 32'd2);
        chk("rearm_pre_per", 100, meas_period, 32'd10);
        exp_nums = 8'd1;
        timeout  = 32'd0;
        cyc(1'b1, 1'b0);
        chk_outs(100, 0, 0, ALL1, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        exp_nums = 8'd9;
        timeout  = 32'd3;
        for (int n = 26; n <= 40; n++) begin
            cyc(1'b0, n >= 32 && n < 35);
        end
        chk_outs(101, 7, 0, ALL1, 0, 3, 1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-MEASURE, then edges without arm are ignored.
        cyc(1'b0, 1'b0);
        exp_nums = 8'd3;
        timeout  = 32'd0;
        cyc(1'b1, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            cyc(1'b0, (n >= 4 && n < 6) || n >= 10);
        end
        chk("rst_pre_cnt", 102, 32'(pulse_cnt), 32'd2);
        chk("rst_pre_per", 102, meas_period, 32'd6);
        #2 reset = 1'b1;
        #1;
        chk_outs(102, 0, 0, ALL1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge ref_clk_500m);
        reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cyc(1'b0, (n % 2) == 1);
        end
        chk_outs(103, 0, 0, ALL1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        exp_nums = 8'd1;
        cyc(1'b1, 1'b0);
        for (int n = 1; n <= 10; n++) begin
            cyc(1'b0, n >= 5 && n < 7);
        end
        chk_outs(104, 5, 0, ALL1, 0, 2, 1, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
